pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three event types:
  - load-use hazards: one-cycle bubble;
  - taken branches/jumps resolved in EX: two-stage flush;
  - multi-cycle data-memory accesses: full freeze, with a timeout watchdog.
- Adds a post-reset purge cycle so pipeline flops that reset to 1 are cleared to bubbles before the first fetch.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int PIPE_REG_AW = 5;
  localparam int REG_ZERO    = 0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is about to write.
import pipe_ctrl_pkg::*;

module hazard_detect #(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != REG_AW'(REG_ZERO)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: purge, load-use bubble, branch flush, memory freeze + watchdog.
// Optional performance counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int REG_AW      = PIPE_REG_AW,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              mem_timeout_err,
  output logic [1:0]        ctrl_state
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              br_flush;
  logic              wd_fire;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Mealy decode; RUN and MEM_WAIT share one priority chain so a branch or
  // load-use held across a freeze takes effect in the release cycle.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mem_stall  = 1'b0;
    br_flush   = 1'b0;
    state_nxt  = state;
    unique case (state)
      ST_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        state_nxt = ST_RUN;
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          br_flush   = 1'b1;
        end else if (load_use) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
        if (wd_fire) state_nxt = ST_ERROR;
      end
      default: state_nxt = ST_ERROR;
    endcase
  end

  assign wd_fire    = (MEM_TIMEOUT > 0) && (state == ST_MEM_WAIT) && mem_stall && (wait_cnt == WAIT_LAST);
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_INIT;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wd_fire) mem_timeout_err <= 1'b1;
      if (state == ST_RUN && mem_stall)
        wait_cnt <= '0;
      else if (state == ST_MEM_WAIT && mem_stall && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic active;
  assign active = (state == ST_RUN) || (state == ST_MEM_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (active && !pc_en) stall_cycles <= stall_cycles + 1'b1;
      if (br_flush)         flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule
